// File: rtl/h14tx_decoding_top_if.sv
// Shared types and the symbol/decoded-output bundle of the HDMI 1.4
// three-channel symbol decoder.
package h14tx_decoding_pkg;
    typedef logic [9:0] symbol_t;
    typedef logic [1:0] ctl_t;
    typedef logic [3:0] data_t;
    typedef logic [7:0] video_t;

    typedef enum logic [2:0] {
        PERIOD_CONTROL,
        PERIOD_VIDEO_PREAMBLE,
        PERIOD_DATA_ISLAND_PREAMBLE,
        PERIOD_VIDEO_GUARD,
        PERIOD_VIDEO_ACTIVE,
        PERIOD_DATA_ISLAND_GUARD,
        PERIOD_DATA_ISLAND_ACTIVE
    } period_t;
endpackage

interface h14tx_decoding_top_if;
    import h14tx_decoding_pkg::*;

    symbol_t [2:0] symbol;
    period_t       period;
    ctl_t    [2:0] ctl;
    data_t   [2:0] data;
    video_t  [2:0] video;
    logic          err;

    modport master (output symbol, input period, ctl, data, video, err);
    modport slave  (input symbol, output period, ctl, data, video, err);
endinterface

// File: rtl/h14tx_decoding_top.sv
// HDMI 1.4 three-channel symbol decoder: classifies each symbol set,
// tracks the transmission period and decodes control/TERC4/TMDS content.
// Every output is registered one cycle after its symbol set.
module h14tx_decoding_top #(
    parameter int MaxPackets  = 18,
    parameter int PreambleLen = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    h14tx_decoding_top_if.slave  bus
);
    import h14tx_decoding_pkg::*;

    localparam int            PcntW    = $clog2(PreambleLen + 1);
    localparam logic [9:0]    MaxSyms  = 10'(MaxPackets * 32);
    localparam symbol_t       GUARD_A  = 10'b1011001100;
    localparam symbol_t       GUARD_B  = 10'b0100110011;

    typedef enum logic [2:0] {
        ST_CONTROL,
        ST_VIDEO_GUARD,
        ST_VIDEO_ACTIVE,
        ST_DI_LEAD_GUARD,
        ST_DI_ACTIVE,
        ST_DI_TRAIL_GUARD
    } state_t;

    // {valid, {c1,c0}}
    function automatic logic [2:0] ctl_decode(input symbol_t q);
        case (q)
            10'b1101010100: return 3'b100;
            10'b0010101011: return 3'b101;
            10'b0101010100: return 3'b110;
            10'b1010101011: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    // {valid, nibble}
    function automatic logic [4:0] terc4_decode(input symbol_t q);
        case (q)
            10'b1010011100: return 5'h10;
            10'b1001100011: return 5'h11;
            10'b1011100100: return 5'h12;
            10'b1011100010: return 5'h13;
            10'b0101110001: return 5'h14;
            10'b0100011110: return 5'h15;
            10'b0110001110: return 5'h16;
            10'b0100111100: return 5'h17;
            10'b1011001100: return 5'h18;
            10'b0100111001: return 5'h19;
            10'b0110011100: return 5'h1a;
            10'b1011000110: return 5'h1b;
            10'b1010001110: return 5'h1c;
            10'b1001110001: return 5'h1d;
            10'b0101100011: return 5'h1e;
            10'b1011000011: return 5'h1f;
            default:        return 5'h00;
        endcase
    endfunction

    function automatic video_t tmds_decode(input symbol_t q);
        logic [7:0] d;
        video_t     v;
        d    = q[9] ? ~q[7:0] : q[7:0];
        v[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            v[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return v;
    endfunction

    logic   [2:0] ctl_valid;
    ctl_t   [2:0] ctl_val;
    logic   [2:0] terc_valid;
    data_t  [2:0] terc_val;
    video_t [2:0] tmds_val;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        assign {ctl_valid[gi], ctl_val[gi]}   = ctl_decode(bus.symbol[gi]);
        assign {terc_valid[gi], terc_val[gi]} = terc4_decode(bus.symbol[gi]);
        assign tmds_val[gi]                   = tmds_decode(bus.symbol[gi]);
    end

    logic all_ctl, vid_pre, di_pre, video_guard, di_guard_hi, di_guard;
    assign all_ctl     = &ctl_valid;
    assign vid_pre     = all_ctl && ctl_val[1] == 2'b01 && ctl_val[2] == 2'b00;
    assign di_pre      = all_ctl && ctl_val[1] == 2'b01 && ctl_val[2] == 2'b01;
    assign video_guard = bus.symbol[0] == GUARD_A && bus.symbol[1] == GUARD_B
                         && bus.symbol[2] == GUARD_A;
    assign di_guard_hi = bus.symbol[1] == GUARD_B && bus.symbol[2] == GUARD_B;
    assign di_guard    = di_guard_hi && terc_valid[0] && terc_val[0][3:2] == 2'b11;

    state_t           state_reg, state_next;
    logic [PcntW-1:0] pcnt_reg, pcnt_next;
    logic             pcnt_di_reg, pcnt_di_next;
    logic [9:0]       scnt_reg, scnt_next;
    period_t          period_reg, period_next;
    ctl_t   [2:0]     ctl_reg, ctl_next;
    data_t  [2:0]     data_reg, data_next;
    video_t [2:0]     video_reg, video_next;
    logic             err_reg, err_next;

    logic pre_video_full, pre_di_full;
    assign pre_video_full = pcnt_reg == PcntW'(PreambleLen) && !pcnt_di_reg;
    assign pre_di_full    = pcnt_reg == PcntW'(PreambleLen) &&  pcnt_di_reg;

    // Preamble run length: a new run starts at 1, a repeat of the same pattern extends it.
    always_comb begin
        pcnt_next    = '0;
        pcnt_di_next = pcnt_di_reg;
        if (vid_pre || di_pre) begin
            pcnt_di_next = di_pre;
            if (pcnt_reg != '0 && pcnt_di_reg == di_pre) begin
                pcnt_next = (pcnt_reg == PcntW'(PreambleLen)) ? pcnt_reg : pcnt_reg + 1'b1;
            end else begin
                pcnt_next = PcntW'(1);
            end
        end
    end

    // Period FSM: next state, reported period, decoded payload and error flag.
    always_comb begin
        state_next  = state_reg;
        period_next = PERIOD_CONTROL;
        data_next   = '0;
        video_next  = '0;
        err_next    = 1'b0;
        scnt_next   = '0;
        for (int c = 0; c < 3; c++) begin
            ctl_next[c] = ctl_valid[c] ? ctl_val[c] : ctl_reg[c];
        end
        case (state_reg)
            ST_CONTROL: begin
                if (vid_pre)     period_next = PERIOD_VIDEO_PREAMBLE;
                else if (di_pre) period_next = PERIOD_DATA_ISLAND_PREAMBLE;
                if (video_guard) begin
                    if (pre_video_full) begin
                        state_next  = ST_VIDEO_GUARD;
                        period_next = PERIOD_VIDEO_GUARD;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (di_guard) begin
                    if (pre_di_full) begin
                        state_next   = ST_DI_LEAD_GUARD;
                        period_next  = PERIOD_DATA_ISLAND_GUARD;
                        data_next[0] = terc_val[0];
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_VIDEO_GUARD: begin
                if (video_guard) begin
                    state_next  = ST_VIDEO_ACTIVE;
                    period_next = PERIOD_VIDEO_GUARD;
                end else begin
                    state_next = ST_CONTROL;
                    err_next   = 1'b1;
                end
            end
            ST_VIDEO_ACTIVE: begin
                if (ctl_valid[0]) begin
                    state_next = ST_CONTROL;
                end else begin
                    period_next = PERIOD_VIDEO_ACTIVE;
                    video_next  = tmds_val;
                end
            end
            ST_DI_LEAD_GUARD: begin
                if (di_guard) begin
                    state_next   = ST_DI_ACTIVE;
                    period_next  = PERIOD_DATA_ISLAND_GUARD;
                    data_next[0] = terc_val[0];
                end else begin
                    state_next = ST_CONTROL;
                    err_next   = 1'b1;
                end
            end
            ST_DI_ACTIVE: begin
                if (di_guard_hi) begin
                    // Trail guard always ends the island; only packet-aligned ones are clean.
                    state_next   = ST_DI_TRAIL_GUARD;
                    period_next  = PERIOD_DATA_ISLAND_GUARD;
                    data_next[0] = terc_valid[0] ? terc_val[0] : 4'h0;
                    err_next     = !di_guard || scnt_reg == '0 || scnt_reg[4:0] != 5'd0;
                end else if (scnt_reg == MaxSyms) begin
                    state_next = ST_CONTROL;
                    err_next   = 1'b1;
                end else begin
                    period_next = PERIOD_DATA_ISLAND_ACTIVE;
                    scnt_next   = scnt_reg + 10'd1;
                    err_next    = !(&terc_valid);
                    for (int c = 0; c < 3; c++) begin
                        data_next[c] = terc_valid[c] ? terc_val[c] : 4'h0;
                    end
                end
            end
            ST_DI_TRAIL_GUARD: begin
                state_next = ST_CONTROL;
                if (di_guard) begin
                    period_next  = PERIOD_DATA_ISLAND_GUARD;
                    data_next[0] = terc_val[0];
                end else begin
                    err_next = 1'b1;
                end
            end
            default: state_next = ST_CONTROL;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_CONTROL;
            pcnt_reg    <= '0;
            pcnt_di_reg <= 1'b0;
            scnt_reg    <= '0;
            period_reg  <= PERIOD_CONTROL;
            ctl_reg     <= '0;
            data_reg    <= '0;
            video_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pcnt_reg    <= pcnt_next;
            pcnt_di_reg <= pcnt_di_next;
            scnt_reg    <= scnt_next;
            period_reg  <= period_next;
            ctl_reg     <= ctl_next;
            data_reg    <= data_next;
            video_reg   <= video_next;
            err_reg     <= err_next;
        end
    end

    assign bus.period = period_reg;
    assign bus.ctl    = ctl_reg;
    assign bus.data   = data_reg;
    assign bus.video  = video_reg;
    assign bus.err    = err_reg;
endmodule

// File: tb/tb_h14tx_decoding_top.sv
// Directed bench for the HDMI 1.4 symbol decoder.
module tb_h14tx_decoding_top;
    import h14tx_decoding_pkg::*;

    localparam symbol_t CTL00   = 10'b1101010100;
    localparam symbol_t CTL01   = 10'b0010101011;
    localparam symbol_t CTL10   = 10'b0101010100;
    localparam symbol_t GUARD_A = 10'b1011001100;
    localparam symbol_t GUARD_B = 10'b0100110011;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    h14tx_decoding_top_if ifc ();

    h14tx_decoding_top #(.MaxPackets(18), .PreambleLen(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    function automatic symbol_t terc4(input int n);
        case (n)
            0:  return 10'b1010011100;
            1:  return 10'b1001100011;
            2:  return 10'b1011100100;
            3:  return 10'b1011100010;
            4:  return 10'b0101110001;
            5:  return 10'b0100011110;
            6:  return 10'b0110001110;
            7:  return 10'b0100111100;
            8:  return 10'b1011001100;
            9:  return 10'b0100111001;
            10: return 10'b0110011100;
            11: return 10'b1011000110;
            12: return 10'b1010001110;
            13: return 10'b1001110001;
            14: return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    // Apply one symbol set, then land 1 time unit after the capturing edge.
    task automatic step(input symbol_t s0, input symbol_t s1, input symbol_t s2);
        ifc.symbol[0] = s0;
        ifc.symbol[1] = s1;
        ifc.symbol[2] = s2;
        @(posedge clk);
        #1;
        $display("t=%0t sym %h %h %h -> period %0d ctl %h data %h video %h err %b",
                 $time, s0, s1, s2, ifc.period, ifc.ctl, ifc.data, ifc.video, ifc.err);
    endtask

    task automatic enter_data_island();
        for (int i = 0; i < 8; i++) step(CTL00, CTL01, CTL01);
        step(terc4(12), GUARD_B, GUARD_B);
        step(terc4(12), GUARD_B, GUARD_B);
    endtask

    task automatic test_reset();
        checks++;
        if (ifc.period !== PERIOD_CONTROL) begin
            fails++; $display("FAIL reset_period: got %0d expected %0d", ifc.period, PERIOD_CONTROL);
        end
        checks++;
        if (ifc.ctl !== '0 || ifc.data !== '0 || ifc.video !== '0) begin
            fails++; $display("FAIL reset_outputs: got ctl %h data %h video %h expected 0", ifc.ctl, ifc.data, ifc.video);
        end
        checks++;
        if (ifc.err !== 1'b0) begin
            fails++; $display("FAIL reset_err: got %b expected 0", ifc.err);
        end
    endtask

    task automatic test_control_idle();
        for (int i = 0; i < 20; i++) begin
            step(CTL00, CTL00, CTL00);
            checks++;
            if (ifc.period !== PERIOD_CONTROL || ifc.ctl !== '0 || ifc.err !== 1'b0) begin
                fails++;
                $display("FAIL idle_%0d: got period %0d ctl %h err %b expected 0 0 0", i, ifc.period, ifc.ctl, ifc.err);
            end
        end
    endtask

    task automatic test_video();
        symbol_t    tmds_sym [4];
        logic [7:0] tmds_byte [4];
        tmds_sym[0] = 10'b1111001100; tmds_byte[0] = 8'h55;
        tmds_sym[1] = 10'b0011001100; tmds_byte[1] = 8'hAA;
        tmds_sym[2] = 10'b1001010101; tmds_byte[2] = 8'h00;
        tmds_sym[3] = 10'b0101010101; tmds_byte[3] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            step(CTL10, CTL01, CTL00);
            checks++;
            if (ifc.period !== PERIOD_VIDEO_PREAMBLE) begin
                fails++; $display("FAIL video_preamble_%0d: got %0d expected %0d", i, ifc.period, PERIOD_VIDEO_PREAMBLE);
            end
        end
        checks++;
        if (ifc.ctl[0] !== 2'b10 || ifc.ctl[1] !== 2'b01 || ifc.ctl[2] !== 2'b00) begin
            fails++; $display("FAIL video_ctl: got %h expected 06", ifc.ctl);
        end
        for (int i = 0; i < 2; i++) begin
            step(GUARD_A, GUARD_B, GUARD_A);
            checks++;
            if (ifc.period !== PERIOD_VIDEO_GUARD || ifc.err !== 1'b0) begin
                fails++; $display("FAIL video_guard_%0d: got period %0d err %b expected %0d 0", i, ifc.period, ifc.err, PERIOD_VIDEO_GUARD);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(tmds_sym[i], tmds_sym[i], tmds_sym[i]);
            checks++;
            if (ifc.period !== PERIOD_VIDEO_ACTIVE || ifc.video[0] !== tmds_byte[i]
                || ifc.video[1] !== tmds_byte[i] || ifc.video[2] !== tmds_byte[i]) begin
                fails++;
                $display("FAIL video_active_%0d: got period %0d video %h expected %0d byte %h",
                         i, ifc.period, ifc.video, PERIOD_VIDEO_ACTIVE, tmds_byte[i]);
            end
        end
        step(CTL00, CTL00, CTL00);
        checks++;
        if (ifc.period !== PERIOD_CONTROL || ifc.video !== '0 || ifc.ctl[0] !== 2'b00 || ifc.err !== 1'b0) begin
            fails++; $display("FAIL video_exit: got period %0d video %h ctl %h err %b expected 0 0 0 0", ifc.period, ifc.video, ifc.ctl, ifc.err);
        end
    endtask

    task automatic test_data_island();
        data_t e0, e1, e2;
        for (int i = 0; i < 8; i++) begin
            step(CTL00, CTL01, CTL01);
            checks++;
            if (ifc.period !== PERIOD_DATA_ISLAND_PREAMBLE) begin
                fails++; $display("FAIL di_preamble_%0d: got %0d expected %0d", i, ifc.period, PERIOD_DATA_ISLAND_PREAMBLE);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(terc4(13), GUARD_B, GUARD_B);
            checks++;
            if (ifc.period !== PERIOD_DATA_ISLAND_GUARD || ifc.data[0] !== 4'd13 || ifc.err !== 1'b0) begin
                fails++; $display("FAIL di_lead_guard_%0d: got period %0d data0 %h err %b expected %0d d 0", i, ifc.period, ifc.data[0], ifc.err, PERIOD_DATA_ISLAND_GUARD);
            end
        end
        for (int i = 0; i < 64; i++) begin
            e0 = data_t'(i % 16);
            e1 = data_t'((i + 5) % 16);
            e2 = data_t'(15 - (i % 16));
            step(terc4(i % 16), terc4((i + 5) % 16), terc4(15 - (i % 16)));
            checks++;
            if (ifc.period !== PERIOD_DATA_ISLAND_ACTIVE || ifc.data[0] !== e0 || ifc.data[1] !== e1
                || ifc.data[2] !== e2 || ifc.err !== 1'b0) begin
                fails++;
                $display("FAIL di_active_%0d: got period %0d data %h err %b expected %0d %h%h%h 0",
                         i, ifc.period, ifc.data, ifc.err, PERIOD_DATA_ISLAND_ACTIVE, e2, e1, e0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(terc4(15), GUARD_B, GUARD_B);
            checks++;
            if (ifc.period !== PERIOD_DATA_ISLAND_GUARD || ifc.data[0] !== 4'd15 || ifc.err !== 1'b0) begin
                fails++; $display("FAIL di_trail_guard_%0d: got period %0d data0 %h err %b expected %0d f 0", i, ifc.period, ifc.data[0], ifc.err, PERIOD_DATA_ISLAND_GUARD);
            end
        end
        step(CTL00, CTL00, CTL00);
        checks++;
        if (ifc.period !== PERIOD_CONTROL || ifc.data !== '0 || ifc.err !== 1'b0) begin
            fails++; $display("FAIL di_exit: got period %0d data %h err %b expected 0 0 0", ifc.period, ifc.data, ifc.err);
        end
    endtask

    task automatic test_short_preamble();
        for (int i = 0; i < 6; i++) step(CTL00, CTL01, CTL00);
        step(GUARD_A, GUARD_B, GUARD_A);
        checks++;
        if (ifc.period !== PERIOD_CONTROL || ifc.err !== 1'b1) begin
            fails++; $display("FAIL short_preamble_guard: got period %0d err %b expected 0 1", ifc.period, ifc.err);
        end
        step(CTL00, CTL00, CTL00);
        checks++;
        if (ifc.period !== PERIOD_CONTROL || ifc.err !== 1'b0) begin
            fails++; $display("FAIL short_preamble_after: got period %0d err %b expected 0 0", ifc.period, ifc.err);
        end
    endtask

    task automatic test_early_trail_guard();
        enter_data_island();
        for (int i = 0; i < 40; i++) step(terc4(i % 16), terc4(i % 16), terc4(i % 16));
        step(terc4(12), GUARD_B, GUARD_B);
        checks++;
        if (ifc.period !== PERIOD_DATA_ISLAND_GUARD || ifc.err !== 1'b1) begin
            fails++; $display("FAIL early_trail_first: got period %0d err %b expected %0d 1", ifc.period, ifc.err, PERIOD_DATA_ISLAND_GUARD);
        end
        step(terc4(12), GUARD_B, GUARD_B);
        checks++;
        if (ifc.period !== PERIOD_DATA_ISLAND_GUARD || ifc.err !== 1'b0) begin
            fails++; $display("FAIL early_trail_second: got period %0d err %b expected %0d 0", ifc.period, ifc.err, PERIOD_DATA_ISLAND_GUARD);
        end
        step(CTL00, CTL00, CTL00);
        checks++;
        if (ifc.period !== PERIOD_CONTROL) begin
            fails++; $display("FAIL early_trail_exit: got period %0d expected 0", ifc.period);
        end
    endtask

    task automatic test_overlong_island();
        logic seen_err;
        seen_err = 1'b0;
        enter_data_island();
        for (int i = 0; i < 576; i++) begin
            step(terc4(i % 16), terc4(i % 16), terc4(i % 16));
            seen_err = seen_err | ifc.err;
        end
        checks++;
        if (ifc.period !== PERIOD_DATA_ISLAND_ACTIVE || seen_err !== 1'b0) begin
            fails++; $display("FAIL overlong_576: got period %0d any_err %b expected %0d 0", ifc.period, seen_err, PERIOD_DATA_ISLAND_ACTIVE);
        end
        step(terc4(3), terc4(3), terc4(3));
        checks++;
        if (ifc.period !== PERIOD_CONTROL || ifc.err !== 1'b1 || ifc.data !== '0) begin
            fails++; $display("FAIL overlong_577: got period %0d err %b data %h expected 0 1 0", ifc.period, ifc.err, ifc.data);
        end
        step(CTL00, CTL00, CTL00);
        checks++;
        if (ifc.period !== PERIOD_CONTROL || ifc.err !== 1'b0) begin
            fails++; $display("FAIL overlong_after: got period %0d err %b expected 0 0", ifc.period, ifc.err);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) step(CTL10, CTL01, CTL00);
        step(GUARD_A, GUARD_B, GUARD_A);
        step(GUARD_A, GUARD_B, GUARD_A);
        step(10'b1111001100, 10'b1111001100, 10'b1111001100);
        checks++;
        if (ifc.period !== PERIOD_VIDEO_ACTIVE || ifc.video[0] !== 8'h55) begin
            fails++; $display("FAIL async_pre: got period %0d video0 %h expected %0d 55", ifc.period, ifc.video[0], PERIOD_VIDEO_ACTIVE);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ifc.period !== PERIOD_CONTROL || ifc.video !== '0 || ifc.ctl !== '0 || ifc.err !== 1'b0) begin
            fails++; $display("FAIL async_reset: got period %0d video %h ctl %h err %b expected 0 0 0 0", ifc.period, ifc.video, ifc.ctl, ifc.err);
        end
        #2 rst_n = 1'b1;
        step(10'b1111001100, 10'b1111001100, 10'b1111001100);
        checks++;
        if (ifc.period !== PERIOD_CONTROL || ifc.video !== '0 || ifc.err !== 1'b0) begin
            fails++; $display("FAIL async_resume: got period %0d video %h err %b expected 0 0 0", ifc.period, ifc.video, ifc.err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ifc.symbol[0] = CTL00;
        ifc.symbol[1] = CTL00;
        ifc.symbol[2] = CTL00;
        #12;
        test_reset();
        rst_n = 1'b1;
        test_control_idle();
        test_video();
        test_data_island();
        test_short_preamble();
        test_early_trail_guard();
        test_overlong_island();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
